mdu_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO result registers for the pipelined CPU's EX stage.
- Sits beside the single-cycle ALU and receives the same source operands.
- Adds signed/unsigned multiply and divide with a configurable latency, plus a busy/done handshake used by the hazard unit to stall dependent instructions.

---
 rtl/mdu_unit.sv | 137 +++++++++++++
 tb/tb_mdu_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// The arithmetic is combinational from latched operands; a down-counter sets the latency.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign busy = (state == RUN);

    always_comb begin
        ext_a   = '0;
        ext_b   = '0;
        product = '0;
        res_hi  = '0;
        res_lo  = '0;
        case (op_q)
            2'b00, 2'b01: begin
                // Signed product: sign-extend to 2*WIDTH, low 2*WIDTH bits of the product are exact.
                if (op_q == 2'b00) begin
                    ext_a = {{WIDTH{a_q[WIDTH-1]}}, a_q};
                    ext_b = {{WIDTH{b_q[WIDTH-1]}}, b_q};
                end else begin
                    ext_a = {{WIDTH{1'b0}}, a_q};
                    ext_b = {{WIDTH{1'b0}}, b_q};
                end
                product = ext_a * ext_b;
                res_hi  = product[2*WIDTH-1:WIDTH];
                res_lo  = product[WIDTH-1:0];
            end
            2'b10: begin
                if (b_q == '0) begin
                    res_lo = ALL_ONES;
                    res_hi = a_q;
                end else if (a_q == MOST_NEG && b_q == ALL_ONES) begin
                    res_lo = a_q;
                    res_hi = '0;
                end else begin
                    res_lo = $unsigned($signed(a_q) / $signed(b_q));
                    res_hi = $unsigned($signed(a_q) % $signed(b_q));
                end
            end
            default: begin
                if (b_q == '0) begin
                    res_lo = ALL_ONES;
                    res_hi = a_q;
                end else begin
                    res_lo = a_q / b_q;
                    res_hi = a_q % b_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                op_q  <= op[1:0];
                                a_q   <= src_a;
                                b_q   <= src_b;
                                count <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                                state <= RUN;
                            end
                            OP_MTHI: hi <= src_a;
                            OP_MTLO: lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Last busy cycle: commit the result and pulse done while returning to IDLE.
                    if (count == CNT_W'(1)) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        done  <= 1'b1;
                        count <= '0;
                        state <= IDLE;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_unit.sv
// Randomised and directed bench for mdu_unit against an integer-arithmetic reference model.
// A 32-bit default instance carries most tests; a 16-bit instance covers the small-parameter case.
module tb_mdu_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start16;
    logic [2:0]  op16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [15:0] hi16, lo16;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    longint unsigned m_hi, m_lo;

    always #5 clk = ~clk;

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    mdu_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op16), .src_a(a16), .src_b(b16),
        .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: interpret operands as w-bit numbers and use 64-bit integer arithmetic.
    function automatic void compute(input int w, input logic [2:0] o,
                                    input longint unsigned a, input longint unsigned b,
                                    output longint unsigned r_hi, output longint unsigned r_lo);
        longint unsigned mask = (64'd1 << w) - 1;
        longint sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        longint sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
        longint unsigned p;
        r_hi = 0;
        r_lo = 0;
        case (o)
            3'd0: begin p = longint'(sa * sb); r_lo = p & mask; r_hi = (p >> w) & mask; end
            3'd1: begin p = a * b; r_lo = p & mask; r_hi = (p >> w) & mask; end
            3'd2: begin
                if (b == 0) begin r_lo = mask; r_hi = a; end
                else if (a == (64'd1 << (w-1)) && b == mask) begin r_lo = a; r_hi = 0; end
                else begin r_lo = longint'(sa / sb) & mask; r_hi = longint'(sa % sb) & mask; end
            end
            default: begin
                if (b == 0) begin r_lo = mask; r_hi = a; end
                else begin r_lo = a / b; r_hi = a % b; end
            end
        endcase
    endfunction

    // Issue one op on the 32-bit instance; optionally fire ignored starts while busy.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit inject);
        longint unsigned r_hi, r_lo;
        logic [63:0] e;
        int cnt = 0;
        int n;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        if (o <= 3'd3) begin
            compute(32, o, a, b, r_hi, r_lo);
            exp_q.push_back({r_hi[31:0], r_lo[31:0]});
            n = (o <= 3'd1) ? 5 : 10;
            while (busy === 1'b1 && cnt < 60) begin
                cnt++;
                if (inject && cnt == 2) begin
                    start = 1'b1; op = 3'd0; src_a = 32'd1; src_b = 32'd1;
                end else if (inject && cnt == 3) begin
                    start = 1'b1; op = 3'd4; src_a = 32'h0000AAAA;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
            start = 1'b0;
            check($sformatf("busy_len op%0d", o), 64'(cnt), 64'(n));
            check($sformatf("done op%0d", o), 64'(done), 64'd1);
            e = exp_q.pop_front();
            m_hi = e[63:32];
            m_lo = e[31:0];
            check($sformatf("hi op%0d", o), 64'(hi), m_hi);
            check($sformatf("lo op%0d", o), 64'(lo), m_lo);
            @(negedge clk);
            check("done_one_cycle", 64'(done), 64'd0);
        end else begin
            if (o == 3'd4) m_hi = a;
            if (o == 3'd5) m_lo = a;
            check($sformatf("busy short op%0d", o), 64'(busy), 64'd0);
            check($sformatf("done short op%0d", o), 64'(done), 64'd0);
            check($sformatf("hi short op%0d", o), 64'(hi), m_hi);
            check($sformatf("lo short op%0d", o), 64'(lo), m_lo);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  ro;
        longint unsigned r_hi, r_lo;
        int cnt;
        int seen;

        reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        m_hi = 0; m_lo = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);

        // Reset in the middle of a multiply aborts it.
        do_op(3'd4, 32'h5, 32'h0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd0; src_a = 32'd7; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre-reset busy", 64'(busy), 64'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_hi = 0; m_lo = 0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("abort no done", 64'(seen), 64'd0);

        // Directed arithmetic cases with literal expectations.
        do_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
        check("mult hi", 64'(hi), 64'hFFFFFFFF);
        check("mult lo", 64'(lo), 64'hFFFFFFFA);
        do_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        check("multu hi", 64'(hi), 64'h00000002);
        check("multu lo", 64'(lo), 64'hFFFFFFFA);
        do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div lo", 64'(lo), 64'hFFFFFFFD);
        check("div hi", 64'(hi), 64'hFFFFFFFF);
        do_op(3'd3, 32'd7, 32'd2, 1'b0);
        check("divu lo", 64'(lo), 64'd3);
        check("divu hi", 64'(hi), 64'd1);
        do_op(3'd3, 32'h12345678, 32'd0, 1'b0);
        check("div0 lo", 64'(lo), 64'hFFFFFFFF);
        check("div0 hi", 64'(hi), 64'h12345678);
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("ovf lo", 64'(lo), 64'h80000000);
        check("ovf hi", 64'(hi), 64'd0);

        // Starts while busy are ignored; then MTHI in idle takes effect.
        do_op(3'd2, 32'd100, 32'd7, 1'b1);
        check("ignored lo", 64'(lo), 64'd14);
        check("ignored hi", 64'(hi), 64'd2);
        do_op(3'd4, 32'h0000AAAA, 32'd0, 1'b0);
        check("mthi lo kept", 64'(lo), 64'd14);

        // Randomised sweep, biased toward divide corner operands.
        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            do_op(ro, ra, rb, 1'b0);
        end

        // Small instance: one-cycle multiply, then a start in the done cycle.
        @(negedge clk);
        start16 = 1'b1; op16 = 3'd1; a16 = 16'hFFFF; b16 = 16'hFFFF;
        @(negedge clk);
        start16 = 1'b0;
        cnt = 0;
        while (busy16 === 1'b1 && cnt < 20) begin cnt++; @(negedge clk); end
        check("w16 busy_len", 64'(cnt), 64'd1);
        check("w16 done", 64'(done16), 64'd1);
        compute(16, 3'd1, 64'hFFFF, 64'hFFFF, r_hi, r_lo);
        check("w16 hi", 64'(hi16), r_hi);
        check("w16 lo", 64'(lo16), r_lo);
        check("w16 hi lit", 64'(hi16), 64'hFFFE);
        check("w16 lo lit", 64'(lo16), 64'h0001);
        start16 = 1'b1; op16 = 3'd3; a16 = 16'd7; b16 = 16'd2;
        @(negedge clk);
        start16 = 1'b0;
        check("w16 accept in done", 64'(busy16), 64'd1);
        cnt = 0;
        while (busy16 === 1'b1 && cnt < 20) begin cnt++; @(negedge clk); end
        check("w16 div busy_len", 64'(cnt), 64'd3);
        check("w16 div done", 64'(done16), 64'd1);
        compute(16, 3'd3, 64'd7, 64'd2, r_hi, r_lo);
        check("w16 div hi", 64'(hi16), r_hi);
        check("w16 div lo", 64'(lo16), r_lo);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
